// File: rtl/prog_clk_divider.sv
// prog_clk_divider: NCH independent programmable clock dividers, each with toggle (square) or pulse output.
// Latency: div_out and tick are registered and change on the edge where terminal count is detected.
// Backpressure: none; en freezes a channel, and config writes to valid channels are always accepted.
//
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   en[NCH]            per-channel count enable
//   mode[NCH]          0 = toggle output, 1 = one-cycle pulse output
//   sync_clr           realigns all channels: clears count, div_out and tick
//   cfg_we/ch/val      half-period write; writes to a channel index >= NCH are dropped
//   div_out[NCH]       divided output per channel
//   tick[NCH]          one-cycle strobe on each terminal count
module prog_clk_divider #(
    parameter int NCH      = 2,
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   mode,
    input  logic             sync_clr,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_val,
    output logic [NCH-1:0]   div_out,
    output logic [NCH-1:0]   tick
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] half_q, half_d;
        logic             dout_q, dout_d;
        logic             tick_q, tick_d;
        logic             wr_hit;
        logic             term;

        // An out-of-range cfg_ch matches no generated channel, so such writes vanish.
        assign wr_hit = cfg_we && (cfg_ch == 4'(g));

        // >= rather than == so a count left above a newly lowered H cannot run away.
        assign term = en[g] && (cnt_q >= half_q);

        always_comb begin
            cnt_d  = cnt_q;
            half_d = half_q;
            dout_d = dout_q;
            tick_d = 1'b0;

            // H is written even when sync_clr coincides.
            if (wr_hit) begin
                half_d = cfg_val;
            end

            if (sync_clr) begin
                cnt_d  = '0;
                dout_d = 1'b0;
            end else if (wr_hit) begin
                // Write beats a same-cycle terminal count: restart, no tick, output holds.
                cnt_d = '0;
            end else if (term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                dout_d = mode[g] ? 1'b1 : ~dout_q;
            end else begin
                if (en[g]) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Pulse mode output is only ever high on a terminal-count cycle; this also
                // drops a high level inherited from toggle mode.
                if (mode[g]) begin
                    dout_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q  <= '0;
                half_q <= CNT_W'(DEF_HALF);
                dout_q <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                half_q <= half_d;
                dout_q <= dout_d;
                tick_q <= tick_d;
            end
        end

        assign div_out[g] = dout_q;
        assign tick[g]    = tick_q;
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
module tb_prog_clk_divider;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   mode;
    logic             sync_clr;
    logic             cfg_we;
    logic [3:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_val;
    logic [NCH-1:0]   div_out;
    logic [NCH-1:0]   tick;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    prog_clk_divider #(
        .NCH      (NCH),
        .CNT_W    (CNT_W),
        .DEF_HALF (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sync_clr (sync_clr),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_val  (cfg_val),
        .div_out  (div_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it for driving and sampling.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst      = 1'b0;
        en       = '0;
        mode     = '0;
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_val  = '0;

        #1;
        chk("rst_div", 32'(div_out), 0);
        chk("rst_tick", 32'(tick), 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        en  = 2'b11;
        cyc = 0;

        // Default H=5, toggle mode: terminal every 6 edges, period 12.
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t1_tick", 32'(tick), (k % 6 == 0) ? 3 : 0);
            chk("t1_div", 32'(div_out), ((k / 6) % 2 == 1) ? 3 : 0);
        end

        // Channel 1 H=0 -> clk/2 with constant tick; channel 0 keeps its phase.
        cfg_we  = 1'b1;
        cfg_ch  = 4'd1;
        cfg_val = 8'd0;
        for (int j = 13; j <= 24; j++) begin
            step();
            cfg_we = 1'b0;
            chk("t2_tick0", 32'(tick[0]), (j % 6 == 0) ? 1 : 0);
            chk("t2_div0", 32'(div_out[0]), (j / 6) % 2);
            chk("t2_tick1", 32'(tick[1]), (j > 13) ? 1 : 0);
            chk("t2_div1", 32'(div_out[1]), (j - 13) % 2);
        end

        // Channel 0 pulse mode with H=3: high one cycle in four.
        cfg_we  = 1'b1;
        cfg_ch  = 4'd0;
        cfg_val = 8'd3;
        mode    = 2'b01;
        for (int j = 25; j <= 34; j++) begin
            step();
            cfg_we = 1'b0;
            chk("t3_div0", 32'(div_out[0]), (j > 25 && (j - 25) % 4 == 0) ? 1 : 0);
            chk("t3_tick0", 32'(tick[0]), (j > 25 && (j - 25) % 4 == 0) ? 1 : 0);
        end
        // Disable channel 0 for 7 cycles with count frozen at 1.
        en = 2'b10;
        for (int j = 35; j <= 41; j++) begin
            step();
            chk("t3_off_div0", 32'(div_out[0]), 0);
            chk("t3_off_tick0", 32'(tick[0]), 0);
        end
        en = 2'b11;
        for (int j = 42; j <= 48; j++) begin
            step();
            chk("t3_resume_div0", 32'(div_out[0]), (j == 44 || j == 48) ? 1 : 0);
        end

        // Back to toggle (output held high, count kept), then write on the terminal cycle.
        mode = 2'b00;
        for (int j = 49; j <= 55; j++) begin
            if (j == 52) begin
                cfg_we  = 1'b1;
                cfg_ch  = 4'd0;
                cfg_val = 8'd2;
            end
            step();
            cfg_we = 1'b0;
            chk("t4_div0", 32'(div_out[0]), (j < 55) ? 1 : 0);
            chk("t4_tick0", 32'(tick[0]), (j == 55) ? 1 : 0);
        end

        // Write to channel 5 must not disturb anything.
        cfg_we  = 1'b1;
        cfg_ch  = 4'd5;
        cfg_val = 8'd0;
        for (int j = 56; j <= 58; j++) begin
            step();
            chk("t4_bad_div0", 32'(div_out[0]), (j == 58) ? 1 : 0);
            chk("t4_bad_tick0", 32'(tick[0]), (j == 58) ? 1 : 0);
            chk("t4_bad_tick1", 32'(tick[1]), 1);
            chk("t4_bad_div1", 32'(div_out[1]), (j - 13) % 2);
        end
        cfg_we = 1'b0;

        // Channel 1 to H=5, then sync_clr with a coincident H=5 write to channel 0.
        cfg_we  = 1'b1;
        cfg_ch  = 4'd1;
        cfg_val = 8'd5;
        step();                         // edge 59
        cfg_we = 1'b0;
        step();                         // edge 60
        step();                         // edge 61
        chk("t5_pre_div0", 32'(div_out[0]), 0);
        chk("t5_pre_div1", 32'(div_out[1]), 1);
        sync_clr = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 4'd0;
        cfg_val  = 8'd5;
        step();                         // edge 62
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
        chk("t5_clr_div", 32'(div_out), 0);
        chk("t5_clr_tick", 32'(tick), 0);
        for (int j = 63; j <= 74; j++) begin
            step();
            chk("t5_tick", 32'(tick), ((j - 62) % 6 == 0) ? 3 : 0);
            chk("t5_div", 32'(div_out), (((j - 62) / 6) % 2 == 1) ? 3 : 0);
        end

        // Move both channels to H=2, reach div_out=11, then reset between edges.
        cfg_we  = 1'b1;
        cfg_ch  = 4'd0;
        cfg_val = 8'd2;
        step();                         // edge 75
        cfg_ch = 4'd1;
        step();                         // edge 76
        cfg_we = 1'b0;
        step();                         // edge 77
        step();                         // edge 78
        step();                         // edge 79
        chk("t6_pre_div", 32'(div_out), 3);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_div", 32'(div_out), 0);
        chk("t6_async_tick", 32'(tick), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        // H must be back to 5: first terminal on the 6th enabled edge.
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t6_post_tick", 32'(tick), (k == 6) ? 3 : 0);
            chk("t6_post_div", 32'(div_out), (k == 6) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
